// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock.
// Optional DIV_ZERO_DETECT_EN: zero divisors are flagged and returned without iterating.
`timescale 1ns/1ps
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH:0]          rem;
    logic [WIDTH-1:0]        q;
    logic [WIDTH-1:0]        dvsr;
    logic [CNT_W-1:0]        cnt;
    logic                    dz;
    logic                    accept;
    logic                    last;
    logic                    zero_in;
    logic [WIDTH:0]          rem_sh;
    logic signed [WIDTH+1:0] diff;
    logic                    fits;
    logic [WIDTH:0]          rem_nxt;
    logic [WIDTH-1:0]        q_nxt;

    // Negative result means the shifted partial remainder is smaller than the divisor.
    function automatic logic signed [WIDTH+1:0] trial_sub(input logic [WIDTH:0]   r,
                                                          input logic [WIDTH-1:0] d);
        logic signed [WIDTH+1:0] a;
        logic signed [WIDTH+1:0] b;
        a = signed'({1'b0, r});
        b = signed'({2'b00, d});
        return a - b;
    endfunction

`ifdef DIV_ZERO_DETECT_EN
    assign zero_in = (divisor == '0);
`else
    assign zero_in = 1'b0;
`endif

    assign accept = (state == IDLE) && in_valid;
    assign last   = (state == BUSY) && (cnt == CNT_W'(1));

    assign rem_sh = {rem[WIDTH-1:0], q[WIDTH-1]};
    assign diff   = trial_sub(rem_sh, dvsr);
    assign fits   = ~diff[WIDTH+1];

    // A flagged zero divisor already holds its final result, so the one BUSY cycle leaves it untouched.
    always_comb begin
        rem_nxt = rem;
        q_nxt   = q;
        if (!dz) begin
            rem_nxt = fits ? diff[WIDTH:0] : rem_sh;
            q_nxt   = {q[WIDTH-2:0], fits};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem       <= '0;
            q         <= '0;
            dvsr      <= '0;
            cnt       <= '0;
            dz        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            dvsr     <= divisor;
            dz       <= zero_in;
            div_zero <= 1'b0;
            if (zero_in) begin
                rem <= {1'b0, dividend};
                q   <= '1;
                cnt <= CNT_W'(1);
            end else begin
                rem <= '0;
                q   <= dividend;
                cnt <= CNT_W'(WIDTH);
            end
        end else if (state == BUSY) begin
            rem <= rem_nxt;
            q   <= q_nxt;
            cnt <= cnt - CNT_W'(1);
            if (last) begin
                quotient  <= q_nxt;
                remainder <= rem_nxt[WIDTH-1:0];
                div_zero  <= dz;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=8): directed vectors, stalls, reset abort, random pairs.
// Expectations for zero divisors follow DIV_ZERO_DETECT_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_seq_divider;
    localparam int W = 8;
`ifdef DIV_ZERO_DETECT_EN
    localparam int ZLAT  = 1;
    localparam bit ZFLAG = 1'b1;
`else
    localparam int ZLAT  = W;
    localparam bit ZFLAG = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;
    logic         busy;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   rdy_mode = 1'b0;
    bit   rdy_force = 1'b1;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Consumer side: fixed or random out_ready, changed just after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_mode ? ($urandom_range(0, 1) == 1) : rdy_force;
        end
    end

    // Monitor: every handshaken result must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got q=%0d r=%0d, expected no result", quotient, remainder);
                end else begin
                    e = sb.pop_front();
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("div_zero", div_zero, e.dz);
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz);
        int n;
        exp_t e;
        n = 0;
        e.q = eq; e.r = er; e.dz = edz;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0d, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lat);
        int k;
        bit ready_ok;
        k = 0;
        ready_ok = !in_ready;
        do begin
            @(posedge clk);
            #1;
            k++;
            if (!out_valid && in_ready) ready_ok = 1'b0;
        end while (!out_valid && k < 50);
        check({name, "_latency"}, k, lat);
        check({name, "_in_ready_low"}, ready_ok, 1);
        check({name, "_busy"}, busy, 1);
    endtask

    task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz, input int lat);
        issue(a, b, eq, er, edz);
        check({name, "_dz_cleared"}, div_zero, 0);
        wait_done(name, lat);
    endtask

    initial begin
        int n;
        logic [W-1:0] a, b;
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [W-1:0] a;
        logic [W-1:0] b;

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 1'b0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_zero", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("d200_7",   8'd200, 8'd7,   8'd28,  8'd4,   1'b0,  W);
        run("d255_1",   8'd255, 8'd1,   8'd255, 8'd0,   1'b0,  W);
        run("d5_9",     8'd5,   8'd9,   8'd0,   8'd5,   1'b0,  W);
        run("d0_3",     8'd0,   8'd3,   8'd0,   8'd0,   1'b0,  W);
        run("d255_255", 8'd255, 8'd255, 8'd1,   8'd0,   1'b0,  W);
        run("d143_0",   8'd143, 8'd0,   8'hFF,  8'h8F,  ZFLAG, ZLAT);
        run("d100_7",   8'd100, 8'd7,   8'd14,  8'd2,   1'b0,  W);

        // Consumer stall in DONE with a new request waiting.
        @(negedge clk);
        rdy_force = 1'b0;
        @(posedge clk);
        #2;
        issue(8'd50, 8'd6, 8'd8, 8'd2, 1'b0);
        wait_done("stall", W);
        dividend = 8'd9;
        divisor  = 8'd3;
        in_valid = 1'b1;
        begin
            exp_t e;
            e.q = 8'd3; e.r = 8'd0; e.dz = 1'b0;
            sb.push_back(e);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_quotient", quotient, 8);
            check("stall_remainder", remainder, 2);
        end
        @(negedge clk);
        rdy_force = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done("after_stall", W);

        // Reset during the fourth iteration of 100/10.
        @(posedge clk);
        #1;
        dividend = 8'd100;
        divisor  = 8'd10;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_quotient", quotient, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run("after_reset", 8'd100, 8'd10, 8'd10, 8'd0, 1'b0, W);

        // Random operands with random consumer stalls.
        @(negedge clk);
        rdy_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(1, 255));
            issue(a, b, a / b, a % b, 1'b0);
        end
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("drain_outstanding", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
